// File: rtl/jump_pkg.sv
// Shared types and default tuning constants for the player's vertical motion.
package jump_pkg;

    typedef enum logic [1:0] {
        J_GROUND = 2'd0,
        J_RISE   = 2'd1,
        J_FALL   = 2'd2
    } jump_state_t;

    localparam int unsigned VW_DEF         = 10;
    localparam int unsigned V0_DEF         = 4;
    localparam int unsigned MAX_FALL_DEF   = 4;
    localparam int unsigned HOLD_MAX_DEF   = 14;
    localparam int unsigned GRAV_DIV_DEF   = 4;
    localparam int unsigned BUF_FRAMES_DEF = 4;

endpackage

// File: rtl/jump_ctrl_if.sv
// Collision/button inputs and velocity outputs between the game logic and jump_ctrl.
interface jump_ctrl_if #(
    parameter int unsigned VW = jump_pkg::VW_DEF
);
    logic                 jump_btn;
    logic                 on_ground;
    logic                 head_bump;
    logic signed [VW-1:0] jump_y_motion;
    logic                 airborne;
    logic                 jump_start;

    modport master (
        output jump_btn, on_ground, head_bump,
        input  jump_y_motion, airborne, jump_start
    );

    modport slave (
        input  jump_btn, on_ground, head_bump,
        output jump_y_motion, airborne, jump_start
    );
endinterface

// File: rtl/jump_ctrl_btn_edge.sv
// Registered rising-edge detector; the reset value decides whether a level held through reset counts.
module btn_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic frame_clk,
    input  logic Reset_n,
    input  logic d,
    output logic press_c
);
    logic d_q;

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) d_q <= RST_VAL;
        else          d_q <= d;
    end

    assign press_c = d & ~d_q;
endmodule

// File: rtl/jump_ctrl.sv
// Per-frame signed y-velocity generator: variable-height jump, gravity, terminal fall, jump buffer.
module jump_ctrl
    import jump_pkg::*;
#(
    parameter int unsigned VW         = VW_DEF,
    parameter int unsigned V0         = V0_DEF,
    parameter int unsigned MAX_FALL   = MAX_FALL_DEF,
    parameter int unsigned HOLD_MAX   = HOLD_MAX_DEF,
    parameter int unsigned GRAV_DIV   = GRAV_DIV_DEF,
    parameter int unsigned BUF_FRAMES = BUF_FRAMES_DEF
) (
    input  logic        frame_clk,
    input  logic        Reset_n,
    jump_ctrl_if.slave  bus
);
    localparam int unsigned HOLD_W = (HOLD_MAX > 0)   ? $clog2(HOLD_MAX + 1)   : 1;
    localparam int unsigned GRAV_W = (GRAV_DIV > 1)   ? $clog2(GRAV_DIV)       : 1;
    localparam int unsigned BUF_W  = (BUF_FRAMES > 0) ? $clog2(BUF_FRAMES + 1) : 1;

    localparam logic signed [VW-1:0] VY_TAKEOFF = -$signed(VW'(V0));
    localparam logic signed [VW-1:0] VY_MAX     = $signed(VW'(MAX_FALL));

    jump_state_t          state_q;
    logic signed [VW-1:0] vy_q;
    logic [HOLD_W-1:0]    hold_cnt;
    logic [GRAV_W-1:0]    grav_cnt;
    logic [BUF_W-1:0]     buf_cnt;
    logic                 hold_active;
    logic                 airborne_q;
    logic                 jump_start_q;
    logic                 press_c;
    logic                 grav_wrap_c;
    logic signed [VW-1:0] vy_inc_c;

    btn_edge #(.RST_VAL(1'b1)) u_btn_edge (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .d         (bus.jump_btn),
        .press_c   (press_c)
    );

    assign grav_wrap_c = (grav_cnt == GRAV_W'(GRAV_DIV - 1));
    assign vy_inc_c    = vy_q + VW'(1);

    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= J_GROUND;
            vy_q         <= '0;
            hold_cnt     <= '0;
            grav_cnt     <= '0;
            buf_cnt      <= '0;
            hold_active  <= 1'b0;
            airborne_q   <= 1'b0;
            jump_start_q <= 1'b0;
        end else begin
            jump_start_q <= 1'b0;
            case (state_q)
                J_GROUND: begin
                    vy_q    <= '0;
                    buf_cnt <= '0;
                    if (!bus.on_ground) begin
                        state_q    <= J_FALL;
                        grav_cnt   <= '0;
                        airborne_q <= 1'b1;
                    end else if (press_c) begin
                        state_q      <= J_RISE;
                        vy_q         <= VY_TAKEOFF;
                        hold_cnt     <= '0;
                        hold_active  <= 1'b1;
                        grav_cnt     <= '0;
                        airborne_q   <= 1'b1;
                        jump_start_q <= 1'b1;
                    end
                end

                J_RISE: begin
                    buf_cnt <= '0;
                    if (bus.head_bump) begin
                        state_q  <= J_FALL;
                        vy_q     <= '0;
                        grav_cnt <= '0;
                    end else if (hold_active && bus.jump_btn && (hold_cnt < HOLD_W'(HOLD_MAX))) begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end else begin
                        // Once the hold window closes it stays closed for the rest of this jump.
                        hold_active <= 1'b0;
                        if (grav_wrap_c) begin
                            vy_q     <= vy_inc_c;
                            grav_cnt <= '0;
                            if (!vy_inc_c[VW-1]) state_q <= J_FALL;
                        end else begin
                            grav_cnt <= grav_cnt + GRAV_W'(1);
                        end
                    end
                end

                J_FALL: begin
                    if (bus.on_ground) begin
                        // A buffered press that is still held launches straight off the landing.
                        if ((buf_cnt != '0) && bus.jump_btn) begin
                            state_q      <= J_RISE;
                            vy_q         <= VY_TAKEOFF;
                            hold_cnt     <= '0;
                            hold_active  <= 1'b1;
                            grav_cnt     <= '0;
                            buf_cnt      <= '0;
                            jump_start_q <= 1'b1;
                        end else begin
                            state_q    <= J_GROUND;
                            vy_q       <= '0;
                            buf_cnt    <= '0;
                            airborne_q <= 1'b0;
                        end
                    end else begin
                        if (press_c)              buf_cnt <= BUF_W'(BUF_FRAMES);
                        else if (buf_cnt != '0)   buf_cnt <= buf_cnt - BUF_W'(1);
                        if (grav_wrap_c) begin
                            grav_cnt <= '0;
                            if (vy_q < VY_MAX) vy_q <= vy_inc_c;
                        end else begin
                            grav_cnt <= grav_cnt + GRAV_W'(1);
                        end
                    end
                end

                default: begin
                    state_q    <= J_GROUND;
                    vy_q       <= '0;
                    airborne_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.jump_y_motion = vy_q;
    assign bus.airborne      = airborne_q;
    assign bus.jump_start    = jump_start_q;
endmodule

// File: tb/tb_jump_ctrl.sv
// Self-checking bench for jump_ctrl: directed scenarios plus random play against a frame-level model.
module tb_jump_ctrl;
    import jump_pkg::*;

    localparam int VW   = 10;
    localparam int V0   = 4;
    localparam int MAXF = 4;
    localparam int HOLD = 14;
    localparam int GDIV = 4;
    localparam int BUFF = 4;

    logic frame_clk = 1'b0;
    logic Reset_n   = 1'b0;
    int   total = 0;
    int   bad   = 0;

    jump_ctrl_if #(.VW(VW)) ifc ();

    jump_ctrl #(
        .VW(VW), .V0(V0), .MAX_FALL(MAXF), .HOLD_MAX(HOLD),
        .GRAV_DIV(GRAV_DIV_DEF), .BUF_FRAMES(BUF_FRAMES_DEF)
    ) dut (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .bus       (ifc.slave)
    );

    always #5 frame_clk = ~frame_clk;

    // Frame-level model: mode 0 = standing, 1 = going up, 2 = coming down.
    int m_mode, m_vy, m_frames_held, m_tick, m_buffer;
    bit m_can_extend, m_prev_btn, m_start;

    function automatic void model_reset();
        m_mode = 0; m_vy = 0; m_frames_held = 0; m_tick = 0; m_buffer = 0;
        m_can_extend = 0; m_prev_btn = 1; m_start = 0;
    endfunction

    function automatic void model_launch();
        m_mode = 1; m_vy = -V0; m_frames_held = 0; m_can_extend = 1;
        m_tick = 0; m_buffer = 0; m_start = 1;
    endfunction

    function automatic void model_step(bit btn, bit gnd, bit bump);
        bit pressed;
        pressed    = btn && !m_prev_btn;
        m_prev_btn = btn;
        m_start    = 0;
        if (m_mode == 0) begin
            m_vy = 0; m_buffer = 0;
            if (!gnd) begin m_mode = 2; m_tick = 0; end
            else if (pressed) model_launch();
        end else if (m_mode == 1) begin
            m_buffer = 0;
            if (bump) begin
                m_mode = 2; m_vy = 0; m_tick = 0;
            end else if (m_can_extend && btn && m_frames_held < HOLD) begin
                m_frames_held++;
            end else begin
                m_can_extend = 0;
                m_tick++;
                if (m_tick == GDIV) begin m_tick = 0; m_vy++; end
                if (m_vy >= 0) begin m_mode = 2; m_tick = 0; end
            end
        end else begin
            if (gnd) begin
                if (m_buffer > 0 && btn) model_launch();
                else begin m_mode = 0; m_vy = 0; m_buffer = 0; end
            end else begin
                if (pressed)           m_buffer = BUFF;
                else if (m_buffer > 0) m_buffer--;
                m_tick++;
                if (m_tick == GDIV) begin
                    m_tick = 0;
                    if (m_vy < MAXF) m_vy++;
                end
            end
        end
    endfunction

    task automatic tick();
        @(posedge frame_clk);
        model_step(ifc.jump_btn, ifc.on_ground, ifc.head_bump);
        #1;
    endtask

    function automatic logic [VW-1:0] enc(int v);
        return VW'(v);
    endfunction

    task automatic settle();
        int n;
        ifc.jump_btn = 1'b0; ifc.on_ground = 1'b0; ifc.head_bump = 1'b0;
        n = 0;
        while (m_mode != 2 && n < 100) begin tick(); n++; end
        total++;
        if (n >= 100) begin bad++; $display("FAIL settle: still rising after %0d frames, required fall", n); end
        ifc.on_ground = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        ifc.jump_btn = 1'b0; ifc.on_ground = 1'b1; ifc.head_bump = 1'b0;
        model_reset();
        repeat (2) @(posedge frame_clk);
        #1;
        total++; if (ifc.jump_y_motion !== enc(0)) begin bad++; $display("FAIL reset_vy: got %0d required 0", $signed(ifc.jump_y_motion)); end
        total++; if (ifc.airborne !== 1'b0) begin bad++; $display("FAIL reset_airborne: got %b required 0", ifc.airborne); end
        total++; if (ifc.jump_start !== 1'b0) begin bad++; $display("FAIL reset_jump_start: got %b required 0", ifc.jump_start); end
        @(negedge frame_clk);
        Reset_n = 1'b1;
        tick();
        total++; if (ifc.airborne !== 1'b0) begin bad++; $display("FAIL post_reset_idle: airborne %b required 0", ifc.airborne); end
    endtask

    function automatic int exp_full_hold(int e);
        int x;
        if (e <= 14) return -4;
        if (e < 30)  return -4 + (e - 14) / 4;
        x = (e - 30) / 4;
        return (x > 4) ? 4 : x;
    endfunction

    task automatic test_full_hold();
        ifc.jump_btn = 1'b1; ifc.on_ground = 1'b1;
        for (int e = 0; e < 50; e++) begin
            tick();
            ifc.on_ground = 1'b0;
            total++;
            if (ifc.jump_y_motion !== enc(exp_full_hold(e)) || ifc.jump_y_motion !== enc(m_vy)) begin
                bad++; $display("FAIL full_hold_vy edge %0d: got %0d required %0d", e, $signed(ifc.jump_y_motion), exp_full_hold(e));
            end
            total++;
            if (ifc.jump_start !== (e == 0) || ifc.airborne !== 1'b1) begin
                bad++; $display("FAIL full_hold_flags edge %0d: start %b airborne %b required %b 1", e, ifc.jump_start, ifc.airborne, e == 0);
            end
        end
        ifc.jump_btn = 1'b0; ifc.on_ground = 1'b1;
        tick();
        total++;
        if (ifc.jump_y_motion !== enc(0) || ifc.airborne !== 1'b0) begin
            bad++; $display("FAIL full_hold_land: vy %0d airborne %b required 0 0", $signed(ifc.jump_y_motion), ifc.airborne);
        end
        tick();
    endtask

    task automatic test_tap();
        int exp;
        ifc.jump_btn = 1'b1; ifc.on_ground = 1'b1;
        for (int e = 0; e <= 16; e++) begin
            tick();
            ifc.jump_btn = 1'b0; ifc.on_ground = 1'b0;
            exp = (e <= 3) ? -4 : -4 + e / 4;
            total++;
            if (ifc.jump_y_motion !== enc(exp) || ifc.jump_y_motion !== enc(m_vy)) begin
                bad++; $display("FAIL tap_vy edge %0d: got %0d required %0d", e, $signed(ifc.jump_y_motion), exp);
            end
        end
        total++;
        if (m_mode != 2 || ifc.airborne !== 1'b1) begin
            bad++; $display("FAIL tap_fall: airborne %b model mode %0d required 1 2", ifc.airborne, m_mode);
        end
        ifc.on_ground = 1'b1;
        tick();
        total++;
        if (ifc.airborne !== 1'b0 || ifc.jump_y_motion !== enc(0)) begin
            bad++; $display("FAIL tap_land: vy %0d airborne %b required 0 0", $signed(ifc.jump_y_motion), ifc.airborne);
        end
        tick();
    endtask

    task automatic test_head_bump();
        int exp;
        ifc.jump_btn = 1'b1; ifc.on_ground = 1'b1;
        for (int e = 0; e <= 9; e++) begin
            ifc.head_bump = (e == 5);
            tick();
            ifc.on_ground = 1'b0;
            exp = (e < 5) ? -4 : (e < 9 ? 0 : 1);
            total++;
            if (ifc.jump_y_motion !== enc(exp) || ifc.airborne !== 1'b1) begin
                bad++; $display("FAIL head_bump edge %0d: vy %0d airborne %b required %0d 1", e, $signed(ifc.jump_y_motion), ifc.airborne, exp);
            end
        end
        ifc.head_bump = 1'b0;
        settle();
    endtask

    task automatic test_ledge();
        ifc.jump_btn = 1'b0; ifc.on_ground = 1'b0;
        for (int e = 0; e <= 4; e++) begin
            tick();
            total++;
            if (ifc.jump_y_motion !== enc(e == 4 ? 1 : 0) || ifc.airborne !== 1'b1) begin
                bad++; $display("FAIL ledge edge %0d: vy %0d airborne %b required %0d 1", e, $signed(ifc.jump_y_motion), ifc.airborne, e == 4 ? 1 : 0);
            end
        end
        ifc.on_ground = 1'b1;
        tick();
        total++;
        if (ifc.jump_y_motion !== enc(0) || ifc.airborne !== 1'b0) begin
            bad++; $display("FAIL ledge_land: vy %0d airborne %b required 0 0", $signed(ifc.jump_y_motion), ifc.airborne);
        end
    endtask

    task automatic test_buffer();
        ifc.jump_btn = 1'b0; ifc.on_ground = 1'b0;
        repeat (5) tick();
        ifc.jump_btn = 1'b1;
        repeat (2) tick();
        ifc.on_ground = 1'b1;
        tick();
        total++;
        if (ifc.jump_y_motion !== enc(-4) || ifc.jump_start !== 1'b1 || ifc.airborne !== 1'b1) begin
            bad++; $display("FAIL buffer_near: vy %0d start %b airborne %b required -4 1 1", $signed(ifc.jump_y_motion), ifc.jump_start, ifc.airborne);
        end
        settle();
        ifc.jump_btn = 1'b0; ifc.on_ground = 1'b0;
        repeat (3) tick();
        ifc.jump_btn = 1'b1;
        repeat (6) tick();
        ifc.on_ground = 1'b1;
        tick();
        total++;
        if (ifc.jump_y_motion !== enc(0) || ifc.jump_start !== 1'b0 || ifc.airborne !== 1'b0) begin
            bad++; $display("FAIL buffer_expired: vy %0d start %b airborne %b required 0 0 0", $signed(ifc.jump_y_motion), ifc.jump_start, ifc.airborne);
        end
        ifc.jump_btn = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_jump();
        ifc.jump_btn = 1'b1; ifc.on_ground = 1'b1;
        tick();
        ifc.on_ground = 1'b0;
        repeat (3) tick();
        #1 Reset_n = 1'b0;
        #1;
        model_reset();
        total++;
        if (ifc.jump_y_motion !== enc(0) || ifc.airborne !== 1'b0 || ifc.jump_start !== 1'b0) begin
            bad++; $display("FAIL reset_mid_rise: vy %0d airborne %b start %b required 0 0 0", $signed(ifc.jump_y_motion), ifc.airborne, ifc.jump_start);
        end
        ifc.on_ground = 1'b1;
        #1 Reset_n = 1'b1;
        for (int e = 0; e < 3; e++) begin
            tick();
            total++;
            if (ifc.airborne !== 1'b0 || ifc.jump_start !== 1'b0) begin
                bad++; $display("FAIL held_through_reset edge %0d: airborne %b start %b required 0 0", e, ifc.airborne, ifc.jump_start);
            end
        end
        ifc.jump_btn = 1'b0;
        tick();
        ifc.jump_btn = 1'b1;
        tick();
        total++;
        if (ifc.jump_y_motion !== enc(-4) || ifc.jump_start !== 1'b1) begin
            bad++; $display("FAIL repress_after_reset: vy %0d start %b required -4 1", $signed(ifc.jump_y_motion), ifc.jump_start);
        end
        settle();
    endtask

    task automatic test_random_play();
        for (int f = 0; f < 3000; f++) begin
            if ($urandom_range(5) == 0)  ifc.jump_btn  = ~ifc.jump_btn;
            if ($urandom_range(9) == 0)  ifc.on_ground = ~ifc.on_ground;
            ifc.head_bump = ($urandom_range(29) == 0);
            tick();
            total++;
            if (ifc.jump_y_motion !== enc(m_vy) || ifc.airborne !== (m_mode != 0) || ifc.jump_start !== m_start) begin
                bad++;
                $display("FAIL random frame %0d: vy %0d air %b start %b required %0d %b %b",
                         f, $signed(ifc.jump_y_motion), ifc.airborne, ifc.jump_start, m_vy, m_mode != 0, m_start);
            end
        end
        ifc.head_bump = 1'b0;
        settle();
    endtask

    initial begin
        test_reset();
        test_full_hold();
        test_tap();
        test_head_bump();
        test_ledge();
        test_buffer();
        test_reset_mid_jump();
        test_random_play();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
